dma_arbiter: RTL and testbench

DMA_ARBITER -- requirements
Module: dma_arbiter

---
 rtl/dma_arbiter.sv | 158 +++++++++++++++
 tb/tb_dma_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_arbiter.sv
// Two-requester round-robin front end for a single DMA engine: grants one
// transfer at a time, launches the matching channel and steers beats to the owner.
`timescale 1ns/1ps
module dma_arbiter #(
    parameter int ADDR_W = 64,
    parameter int SIZE_W = 43,
    parameter int DATA_W = 512
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req_valid,
    input  logic [1:0]          req_write,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [2*SIZE_W-1:0] req_size,
    output logic [1:0]          req_ready,
    output logic [1:0]          cpl_done,
    output logic [1:0]          rd_valid,
    input  logic [1:0]          rd_en,
    input  logic [2*DATA_W-1:0] wr_data,
    output logic [1:0]          wr_ready,
    input  logic [1:0]          wr_en,
    output logic [ADDR_W-1:0]   dma_addr,
    output logic [SIZE_W-1:0]   dma_size,
    output logic                dma_rd_go,
    output logic                dma_wr_go,
    output logic                dma_rd_en,
    output logic                dma_wr_en,
    output logic [DATA_W-1:0]   dma_wr_data,
    input  logic [DATA_W-1:0]   dma_rd_data,
    input  logic                dma_empty,
    input  logic                dma_full,
    input  logic                dma_rd_done,
    input  logic                dma_wr_done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        XFER   = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                owner;
    logic                last_grant;
    logic                lat_write;
    logic [ADDR_W-1:0]   lat_addr;
    logic [SIZE_W-1:0]   lat_size;
    logic [SIZE_W-1:0]   beats;
    logic [SIZE_W-1:0]   beats_inc;
    logic                grant_any;
    logic                grant_idx;
    logic [ADDR_W-1:0]   sel_addr;
    logic [SIZE_W-1:0]   sel_size;
    logic                beats_left;
    logic                beat_fire;
    logic                count_reached;
    logic                done_sel;

    // Read data reaches the requesters outside this block.
    logic                unused_rd_data;
    assign unused_rd_data = ^dma_rd_data;

    always_comb begin
        grant_any = |req_valid;
        grant_idx = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
        sel_addr  = grant_idx ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
        sel_size  = grant_idx ? req_size[2*SIZE_W-1:SIZE_W] : req_size[SIZE_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            lat_write  <= 1'b0;
            lat_addr   <= '0;
            lat_size   <= '0;
            beats      <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && grant_any) begin
                owner     <= grant_idx;
                lat_write <= req_write[grant_idx];
                lat_addr  <= sel_addr;
                lat_size  <= sel_size;
            end
            if (state == LAUNCH) begin
                beats <= '0;
            end else if (beat_fire) begin
                beats <= beats_inc;
            end
            if (state == FINISH) begin
                last_grant <= owner;
            end
        end
    end

    // Beat handshakes; the current beat counts toward completion so the
    // last beat plus done reaches FINISH on the very next edge.
    always_comb begin
        rd_valid   = '0;
        wr_ready   = '0;
        beats_left = (beats < lat_size);
        if (state == XFER && !lat_write && !dma_empty && beats_left) begin
            rd_valid[owner] = 1'b1;
        end
        if (state == XFER && lat_write && !dma_full && beats_left) begin
            wr_ready[owner] = 1'b1;
        end
        dma_rd_en     = rd_en[owner] & rd_valid[owner];
        dma_wr_en     = wr_en[owner] & wr_ready[owner];
        beat_fire     = dma_rd_en | dma_wr_en;
        beats_inc     = beats + 1'b1;
        count_reached = (beats == lat_size) || (beat_fire && (beats_inc == lat_size));
        done_sel      = lat_write ? dma_wr_done : dma_rd_done;
        dma_wr_data   = owner ? wr_data[2*DATA_W-1:DATA_W] : wr_data[DATA_W-1:0];
        dma_addr      = (state != IDLE) ? lat_addr : '0;
        dma_size      = (state != IDLE) ? lat_size : '0;
    end

    always_comb begin
        state_next = state;
        req_ready  = '0;
        cpl_done   = '0;
        dma_rd_go  = 1'b0;
        dma_wr_go  = 1'b0;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    req_ready[grant_idx] = rst_n;
                    state_next           = LAUNCH;
                end
            end
            LAUNCH: begin
                if (lat_size == '0) begin
                    state_next = FINISH;
                end else begin
                    dma_wr_go  = lat_write;
                    dma_rd_go  = ~lat_write;
                    state_next = XFER;
                end
            end
            XFER: begin
                if (count_reached && done_sel) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                cpl_done[owner] = 1'b1;
                state_next      = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dma_arbiter.sv
// Directed scoreboard bench for dma_arbiter: expected events are queued with
// their cycle numbers and a negedge monitor matches every observed pulse.
`timescale 1ns/1ps
module tb_dma_arbiter;

    localparam int ADDR_W = 64;
    localparam int SIZE_W = 43;
    localparam int DATA_W = 512;

    localparam int EV_READY = 0;
    localparam int EV_RDGO  = 1;
    localparam int EV_WRGO  = 2;
    localparam int EV_RDEN  = 3;
    localparam int EV_WREN  = 4;
    localparam int EV_CPL   = 5;

    logic                clk;
    logic                rst_n;
    logic [1:0]          req_valid;
    logic [1:0]          req_write;
    logic [2*ADDR_W-1:0] req_addr;
    logic [2*SIZE_W-1:0] req_size;
    logic [1:0]          req_ready;
    logic [1:0]          cpl_done;
    logic [1:0]          rd_valid;
    logic [1:0]          rd_en;
    logic [2*DATA_W-1:0] wr_data;
    logic [1:0]          wr_ready;
    logic [1:0]          wr_en;
    logic [ADDR_W-1:0]   dma_addr;
    logic [SIZE_W-1:0]   dma_size;
    logic                dma_rd_go;
    logic                dma_wr_go;
    logic                dma_rd_en;
    logic                dma_wr_en;
    logic [DATA_W-1:0]   dma_wr_data;
    logic [DATA_W-1:0]   dma_rd_data;
    logic                dma_empty;
    logic                dma_full;
    logic                dma_rd_done;
    logic                dma_wr_done;

    typedef struct {
        int          kind;
        int          cyc;
        logic [63:0] a;
        logic [63:0] b;
    } ev_t;

    ev_t               exp_q[$];
    int                checks = 0;
    int                errors = 0;
    int                cyc = 0;
    int                t;
    logic [DATA_W-1:0] data0;
    logic [DATA_W-1:0] data1;

    dma_arbiter #(.ADDR_W(ADDR_W), .SIZE_W(SIZE_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
        .req_ready(req_ready), .cpl_done(cpl_done),
        .rd_valid(rd_valid), .rd_en(rd_en), .wr_data(wr_data), .wr_ready(wr_ready), .wr_en(wr_en),
        .dma_addr(dma_addr), .dma_size(dma_size), .dma_rd_go(dma_rd_go), .dma_wr_go(dma_wr_go),
        .dma_rd_en(dma_rd_en), .dma_wr_en(dma_wr_en), .dma_wr_data(dma_wr_data),
        .dma_rd_data(dma_rd_data), .dma_empty(dma_empty), .dma_full(dma_full),
        .dma_rd_done(dma_rd_done), .dma_wr_done(dma_wr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input int kind, input int c, input logic [63:0] a, input logic [63:0] b);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.a    = a;
        e.b    = b;
        exp_q.push_back(e);
    endtask

    task automatic score(input int kind, input logic [63:0] a, input logic [63:0] b);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_event kind=%0d cyc=%0d a=%h b=%h, required no event", kind, cyc, a, b);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.a != a || e.b != b) begin
                errors++;
                $display("[TB] FAIL event got kind=%0d cyc=%0d a=%h b=%h, required kind=%0d cyc=%0d a=%h b=%h",
                         kind, cyc, a, b, e.kind, e.cyc, e.a, e.b);
            end
        end
    endtask

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s got %h, required %h", name, actual, required);
        end
    endtask

    task automatic apply_stimulus(input logic [1:0] valid, input logic [1:0] write,
                                  input logic [63:0] addr0, input logic [SIZE_W-1:0] size0,
                                  input logic [63:0] addr1, input logic [SIZE_W-1:0] size1);
        req_write = write;
        req_addr  = {addr1, addr0};
        req_size  = {size1, size0};
        req_valid = valid;
    endtask

    // Monitor: every active output pulse must match the head of the queue.
    always @(negedge clk) begin
        if (req_ready != 2'b00) score(EV_READY, {62'b0, req_ready}, 64'd0);
        if (dma_rd_go) score(EV_RDGO, dma_addr, 64'(dma_size));
        if (dma_wr_go) score(EV_WRGO, dma_addr, 64'(dma_size));
        if (dma_rd_en) score(EV_RDEN, 64'd0, 64'd0);
        if (dma_wr_en) score(EV_WREN, dma_wr_data[63:0], dma_wr_data[DATA_W-1:DATA_W-64]);
        if (cpl_done != 2'b00) score(EV_CPL, {62'b0, cpl_done}, 64'd0);
    end

    initial begin
        data0 = {8{64'h0000_0000_DEAD_BEEF}};
        data1 = {64'h1111_2222_3333_4444, {6{64'hA5A5_0101_CAFE_F00D}}, 64'h5555_6666_7777_8888};
        rst_n       = 1'b0;
        wr_data     = {data1, data0};
        dma_rd_data = '0;
        rd_en       = 2'b11;
        wr_en       = 2'b11;
        dma_empty   = 1'b0;
        dma_full    = 1'b0;
        dma_rd_done = 1'b1;
        dma_wr_done = 1'b1;
        apply_stimulus(2'b11, 2'b01, 64'h1234, 43'd5, 64'h5678, 43'd6);

        // Reset state with every input trying to provoke activity
        tick();
        tick();
        check_output("rst_req_ready", {62'b0, req_ready}, 64'd0);
        check_output("rst_cpl_done", {62'b0, cpl_done}, 64'd0);
        check_output("rst_rd_valid", {62'b0, rd_valid}, 64'd0);
        check_output("rst_wr_ready", {62'b0, wr_ready}, 64'd0);
        check_output("rst_go_en", {60'b0, dma_rd_go, dma_wr_go, dma_rd_en, dma_wr_en}, 64'd0);
        check_output("rst_dma_addr", dma_addr, 64'd0);
        check_output("rst_dma_size", 64'(dma_size), 64'd0);

        apply_stimulus(2'b00, 2'b00, 64'h0, 43'd0, 64'h0, 43'd0);
        dma_rd_done = 1'b0;
        dma_wr_done = 1'b0;
        tick();
        rst_n = 1'b1;

        // Lone read of 4 lines by requester 0
        tick();
        t = cyc;
        apply_stimulus(2'b01, 2'b00, 64'h1000, 43'd4, 64'h0, 43'd0);
        expect_ev(EV_READY, t, 64'd1, 64'd0);
        expect_ev(EV_RDGO, t + 1, 64'h1000, 64'd4);
        for (int i = 2; i <= 5; i++) expect_ev(EV_RDEN, t + i, 64'd0, 64'd0);
        expect_ev(EV_CPL, t + 6, 64'd1, 64'd0);
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 1) req_valid = 2'b00;
            if (k == 5) dma_rd_done = 1'b1;
            if (k == 7) dma_rd_done = 1'b0;
        end
        check_output("lone_read_drain", 64'(exp_q.size()), 64'd0);

        // Contention from reset: grants alternate 0,1,0,1
        tick();
        rst_n = 1'b0;
        apply_stimulus(2'b11, 2'b00, 64'h2000, 43'd1, 64'h3000, 43'd1);
        rd_en       = 2'b11;
        dma_rd_done = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        t = cyc;
        for (int r = 0; r < 4; r++) begin
            expect_ev(EV_READY, t + 4*r, (r % 2 == 1) ? 64'd2 : 64'd1, 64'd0);
            expect_ev(EV_RDGO, t + 4*r + 1, (r % 2 == 1) ? 64'h3000 : 64'h2000, 64'd1);
            expect_ev(EV_RDEN, t + 4*r + 2, 64'd0, 64'd0);
            expect_ev(EV_CPL, t + 4*r + 3, (r % 2 == 1) ? 64'd2 : 64'd1, 64'd0);
        end
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 16) begin
                req_valid   = 2'b00;
                dma_rd_done = 1'b0;
            end
        end
        check_output("contention_drain", 64'(exp_q.size()), 64'd0);

        // Write of 3 lines by requester 1 with dma_full toggling
        tick();
        rd_en       = 2'b00;
        wr_en       = 2'b11;
        dma_full    = 1'b1;
        dma_wr_done = 1'b1;
        apply_stimulus(2'b10, 2'b10, 64'h0, 43'd0, 64'h4000, 43'd3);
        t = cyc;
        expect_ev(EV_READY, t, 64'd2, 64'd0);
        expect_ev(EV_WRGO, t + 1, 64'h4000, 64'd3);
        for (int i = 0; i < 3; i++) expect_ev(EV_WREN, t + 3 + 2*i, data1[63:0], data1[DATA_W-1:DATA_W-64]);
        expect_ev(EV_CPL, t + 8, 64'd2, 64'd0);
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 1) req_valid = 2'b00;
            dma_full = (k % 2 == 0);
            if (k == 9) begin
                dma_wr_done = 1'b0;
                dma_full    = 1'b0;
            end
        end
        check_output("backpressure_drain", 64'(exp_q.size()), 64'd0);

        // Stale read-done level held high across a 2-line read
        tick();
        wr_en       = 2'b00;
        rd_en       = 2'b01;
        dma_rd_done = 1'b1;
        dma_empty   = 1'b0;
        apply_stimulus(2'b01, 2'b00, 64'h5000, 43'd2, 64'h0, 43'd0);
        t = cyc;
        expect_ev(EV_READY, t, 64'd1, 64'd0);
        expect_ev(EV_RDGO, t + 1, 64'h5000, 64'd2);
        expect_ev(EV_RDEN, t + 3, 64'd0, 64'd0);
        expect_ev(EV_RDEN, t + 4, 64'd0, 64'd0);
        expect_ev(EV_CPL, t + 5, 64'd1, 64'd0);
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 1) req_valid = 2'b00;
            if (k == 2) dma_empty = 1'b1;
            if (k == 3) dma_empty = 1'b0;
            if (k == 6) dma_rd_done = 1'b0;
        end
        check_output("stale_done_drain", 64'(exp_q.size()), 64'd0);

        // Zero-size request from requester 1: no go pulse
        tick();
        apply_stimulus(2'b10, 2'b00, 64'h0, 43'd0, 64'h8000, 43'd0);
        t = cyc;
        expect_ev(EV_READY, t, 64'd2, 64'd0);
        expect_ev(EV_CPL, t + 2, 64'd2, 64'd0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            if (k == 1) req_valid = 2'b00;
        end
        check_output("zero_size_drain", 64'(exp_q.size()), 64'd0);

        // Reset after the first of four beats, then a fresh transfer
        tick();
        rd_en = 2'b01;
        apply_stimulus(2'b01, 2'b00, 64'h6000, 43'd4, 64'h0, 43'd0);
        t = cyc;
        expect_ev(EV_READY, t, 64'd1, 64'd0);
        expect_ev(EV_RDGO, t + 1, 64'h6000, 64'd4);
        expect_ev(EV_RDEN, t + 2, 64'd0, 64'd0);
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_output("midrst_rd_valid", {62'b0, rd_valid}, 64'd0);
        check_output("midrst_go_en", {60'b0, dma_rd_go, dma_wr_go, dma_rd_en, dma_wr_en}, 64'd0);
        check_output("midrst_dma_addr", dma_addr, 64'd0);
        check_output("midrst_dma_size", 64'(dma_size), 64'd0);
        tick();
        tick();
        check_output("midrst_cpl_done", {62'b0, cpl_done}, 64'd0);
        check_output("midrst_drain", 64'(exp_q.size()), 64'd0);
        rst_n = 1'b1;
        tick();
        dma_rd_done = 1'b1;
        apply_stimulus(2'b01, 2'b00, 64'h7000, 43'd1, 64'h0, 43'd0);
        t = cyc;
        expect_ev(EV_READY, t, 64'd1, 64'd0);
        expect_ev(EV_RDGO, t + 1, 64'h7000, 64'd1);
        expect_ev(EV_RDEN, t + 2, 64'd0, 64'd0);
        expect_ev(EV_CPL, t + 3, 64'd1, 64'd0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 1) req_valid = 2'b00;
            if (k == 5) dma_rd_done = 1'b0;
        end
        check_output("post_reset_drain", 64'(exp_q.size()), 64'd0);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
